chimp_control: RTL

- Game-sequencing FSM for the chimp memory test. It sits directly upstream of the chimp board datapath.
- It clears the board and drives a one-number-at-a-time load handshake with random cell placement.
- It controls show/hide of the numbers, tracks the next expected number, and consumes click verdicts.
- It manages level, strikes, score and game-over, and exports status to the display/HUD logic.

---
 rtl/chimp_pkg.sv | 18 +
 rtl/chimp_pause_timer.sv | 29 ++
 rtl/chimp_control.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/chimp_pkg.sv
// Shared types and constants for the chimp memory-test game controller.
package chimp_pkg;

    localparam int BOARD_DIM = 8;
    localparam int NUM_W     = 5;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD_REQ,
        LOAD_WAIT,
        PLAY,
        WIN_PAUSE,
        FAIL_PAUSE,
        GAME_OVER
    } state_t;

endpackage

// File: rtl/chimp_pause_timer.sv
// Down-counter for the result-display dwell; done is high on the last pause cycle.
module chimp_pause_timer #(
    parameter int CYCLES = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic done
);

    localparam int W = $clog2(CYCLES + 1);
    // Loading CYCLES-1 makes the pause state last exactly CYCLES cycles.
    localparam logic [W-1:0] RELOAD = W'(CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/chimp_control.sv
// Game-sequencing FSM for the chimp memory test: clear, load, play, pause, game over.
module chimp_control
    import chimp_pkg::*;
#(
    parameter int START_COUNT  = 4,
    parameter int MAX_COUNT    = 31,
    parameter int MAX_STRIKES  = 3,
    parameter int PAUSE_CYCLES = 50000000
) (
    input  logic             clk,
    input  logic             iReset,
    input  logic             iStart,
    input  logic             iDoneLoad,
    input  logic             iChoseCorrectNum,
    input  logic             iChoseWrongNum,
    output logic             oResetBoard,
    output logic             oLoadEnable,
    output logic [NUM_W-1:0] oNumToLoad,
    output logic             oShowEnable,
    output logic [NUM_W-1:0] oNumToChoose,
    output logic [NUM_W-1:0] oLevel,
    output logic [1:0]       oStrikes,
    output logic [NUM_W-1:0] oScore,
    output logic             oRoundWin,
    output logic             oRoundFail,
    output logic             oGameOver,
    output logic [2:0]       oState
);

    localparam logic [NUM_W:0]   START_W      = (NUM_W + 1)'(START_COUNT);
    localparam logic [NUM_W:0]   MAX_W        = (NUM_W + 1)'(MAX_COUNT);
    localparam logic [1:0]       STRIKE_LIMIT = 2'(MAX_STRIKES);
    localparam logic [NUM_W-1:0] ONE          = NUM_W'(1);

    state_t           state, state_n;
    logic [NUM_W-1:0] num_to_load_n, num_to_choose_n, level_n, score_n;
    logic [1:0]       strikes_n, strikes_inc;
    logic             show_n;
    logic [NUM_W:0]   count_sum;
    logic [NUM_W-1:0] count;
    logic             pause_load, pause_done;

    assign count_sum   = {1'b0, oLevel} + START_W;
    assign count       = (count_sum > MAX_W) ? MAX_W[NUM_W-1:0] : count_sum[NUM_W-1:0];
    assign strikes_inc = oStrikes + 2'd1;
    assign oState      = state;

    always_comb begin
        state_n         = state;
        num_to_load_n   = oNumToLoad;
        num_to_choose_n = oNumToChoose;
        show_n          = oShowEnable;
        level_n         = oLevel;
        strikes_n       = oStrikes;
        score_n         = oScore;

        case (state)
            IDLE: begin
                if (iStart) begin
                    level_n   = '0;
                    strikes_n = '0;
                    score_n   = '0;
                    state_n   = CLEAR;
                end
            end
            CLEAR:    state_n = LOAD_REQ;
            LOAD_REQ: state_n = LOAD_WAIT;
            LOAD_WAIT: begin
                // A missing ack means the random cell was occupied; retry the same number.
                if (!iDoneLoad) begin
                    state_n = LOAD_REQ;
                end else if (oNumToLoad == count) begin
                    state_n = PLAY;
                end else begin
                    num_to_load_n = oNumToLoad + ONE;
                    state_n       = LOAD_REQ;
                end
            end
            PLAY: begin
                if (iChoseWrongNum) begin
                    strikes_n = strikes_inc;
                    state_n   = (strikes_inc == STRIKE_LIMIT) ? GAME_OVER : FAIL_PAUSE;
                end else if (iChoseCorrectNum) begin
                    if (oNumToChoose == ONE) begin
                        show_n = 1'b0;
                    end
                    if (oNumToChoose == count) begin
                        score_n = count;
                        state_n = WIN_PAUSE;
                    end else begin
                        num_to_choose_n = oNumToChoose + ONE;
                    end
                end
            end
            WIN_PAUSE: begin
                if (pause_done) begin
                    level_n = (oLevel == '1) ? oLevel : oLevel + ONE;
                    state_n = CLEAR;
                end
            end
            FAIL_PAUSE: begin
                if (pause_done) begin
                    state_n = CLEAR;
                end
            end
            GAME_OVER: begin
                if (iStart) begin
                    level_n   = '0;
                    strikes_n = '0;
                    state_n   = CLEAR;
                end
            end
            default: state_n = IDLE;
        endcase

        if (state_n == CLEAR) begin
            num_to_load_n   = ONE;
            num_to_choose_n = ONE;
            show_n          = 1'b1;
        end
        if (state_n == FAIL_PAUSE || state_n == GAME_OVER) begin
            show_n = 1'b1;
        end
    end

    assign pause_load = (state == PLAY) && (state_n == WIN_PAUSE || state_n == FAIL_PAUSE);

    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            state        <= IDLE;
            oResetBoard  <= 1'b0;
            oLoadEnable  <= 1'b0;
            oNumToLoad   <= '0;
            oShowEnable  <= 1'b0;
            oNumToChoose <= '0;
            oLevel       <= '0;
            oStrikes     <= '0;
            oScore       <= '0;
            oRoundWin    <= 1'b0;
            oRoundFail   <= 1'b0;
            oGameOver    <= 1'b0;
        end else begin
            state        <= state_n;
            oResetBoard  <= (state_n == CLEAR);
            oLoadEnable  <= (state_n == LOAD_REQ);
            oNumToLoad   <= num_to_load_n;
            oShowEnable  <= show_n;
            oNumToChoose <= num_to_choose_n;
            oLevel       <= level_n;
            oStrikes     <= strikes_n;
            oScore       <= score_n;
            oRoundWin    <= (state_n == WIN_PAUSE);
            oRoundFail   <= (state_n == FAIL_PAUSE);
            oGameOver    <= (state_n == GAME_OVER);
        end
    end

    chimp_pause_timer #(
        .CYCLES (PAUSE_CYCLES)
    ) u_pause_timer (
        .clk  (clk),
        .rst  (iReset),
        .load (pause_load),
        .done (pause_done)
    );

endmodule
